fifo_param: RTL and testbench

- Parametrised synchronous FIFO: storage, read/write pointers, occupancy count and an operation-status state machine in one block.
- Successor to the team's fixed 8-deep FIFO. Adds configurable width and depth, almost-full/almost-empty thresholds and registered ack/error handshakes.
- Adds true simultaneous read+write. The previous generation treated that case as a no-op.
- Sits between a producer and a consumer in the same clock domain.

---
 rtl/fifo_param.sv | 121 ++++++++++++
 tb/tb_fifo_param.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/fifo_param.sv
// Parametrised single-clock FIFO with occupancy flags, registered ack/error
// handshakes and a status state machine reporting the previous cycle's operation.
module fifo_param #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 3,
  parameter int unsigned AF_LEVEL   = 6,
  parameter int unsigned AE_LEVEL   = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic [ADDR_WIDTH:0]   data_count,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  wr_ack,
  output logic                  wr_err,
  output logic                  rd_ack,
  output logic                  rd_err,
  output logic [2:0]            state
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
  localparam int unsigned CNT_W = ADDR_WIDTH + 1;

  typedef enum logic [2:0] {
    ST_INIT     = 3'b000,
    ST_WRITE    = 3'b001,
    ST_READ     = 3'b010,
    ST_WR_ERROR = 3'b011,
    ST_RD_ERROR = 3'b100,
    ST_WR_RD    = 3'b101,
    ST_NO_OP    = 3'b111
  } state_t;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  state_t                state_q;
  logic                  wr_accept_c;
  logic                  rd_accept_c;

  // Flags decode the registered occupancy count
  assign full         = (data_count == CNT_W'(DEPTH));
  assign empty        = (data_count == '0);
  assign almost_full  = (data_count >= CNT_W'(AF_LEVEL));
  assign almost_empty = (data_count <= CNT_W'(AE_LEVEL));
  assign state        = state_q;

  // A read frees a slot in the same cycle, so a full FIFO still takes a write alongside it
  assign rd_accept_c = rd_en & ~empty;
  assign wr_accept_c = wr_en & (~full | rd_accept_c);

  // Storage is intentionally left out of reset
  always_ff @(posedge clk) begin
    if (wr_accept_c) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      data_count <= '0;
      rd_data    <= '0;
    end else begin
      if (wr_accept_c) begin
        wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
      end
      if (rd_accept_c) begin
        rd_ptr  <= rd_ptr + ADDR_WIDTH'(1);
        rd_data <= mem[rd_ptr];
      end
      case ({wr_accept_c, rd_accept_c})
        2'b10:   data_count <= data_count + CNT_W'(1);
        2'b01:   data_count <= data_count - CNT_W'(1);
        default: data_count <= data_count;
      endcase
    end
  end

  // Handshakes and status reflect the requests seen at this edge
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ack  <= 1'b0;
      wr_err  <= 1'b0;
      rd_ack  <= 1'b0;
      rd_err  <= 1'b0;
      state_q <= ST_INIT;
    end else begin
      wr_ack <= wr_en & wr_accept_c;
      wr_err <= wr_en & ~wr_accept_c;
      rd_ack <= rd_en & rd_accept_c;
      rd_err <= rd_en & ~rd_accept_c;

      if (wr_en && rd_en && !empty) begin
        state_q <= ST_WR_RD;
      end else if (wr_en && rd_en) begin
        state_q <= ST_RD_ERROR;
      end else if (wr_en && full) begin
        state_q <= ST_WR_ERROR;
      end else if (wr_en) begin
        state_q <= ST_WRITE;
      end else if (rd_en && empty) begin
        state_q <= ST_RD_ERROR;
      end else if (rd_en) begin
        state_q <= ST_READ;
      end else if (state_q == ST_INIT) begin
        state_q <= ST_INIT;
      end else begin
        state_q <= ST_NO_OP;
      end
    end
  end

endmodule

// File: tb/tb_fifo_param.sv
// Directed self-checking bench for fifo_param at its default 32x8 configuration.
module tb_fifo_param;

  logic        clk;
  logic        reset_n;
  logic        wr_en;
  logic [31:0] wr_data;
  logic        rd_en;
  logic [31:0] rd_data;
  logic [3:0]  data_count;
  logic        full;
  logic        empty;
  logic        almost_full;
  logic        almost_empty;
  logic        wr_ack;
  logic        wr_err;
  logic        rd_ack;
  logic        rd_err;
  logic [2:0]  state;

  int unsigned total = 0;
  int unsigned bad   = 0;
  logic [31:0] sb [$];
  logic [31:0] exp_word;

  fifo_param dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .wr_en        (wr_en),
    .wr_data      (wr_data),
    .rd_en        (rd_en),
    .rd_data      (rd_data),
    .data_count   (data_count),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .wr_ack       (wr_ack),
    .wr_err       (wr_err),
    .rd_ack       (rd_ack),
    .rd_err       (rd_err),
    .state        (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Advance one edge and settle just after it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n = 1'b0;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    wr_data = '0;
    #1;
    check("rst_count", 32'(data_count), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_ae", 32'(almost_empty), 32'd1);
    check("rst_full", 32'(full), 32'd0);
    check("rst_state", 32'(state), 32'd0);
    check("rst_acks", 32'({wr_ack, wr_err, rd_ack, rd_err}), 32'd0);
    check("rst_rd_data", rd_data, 32'd0);

    @(negedge clk);
    reset_n = 1'b1;
    step();
    check("idle_init", 32'(state), 32'd0);

    // Fill with 0x11..0x88
    for (int i = 0; i < 8; i++) begin
      wr_en   = 1'b1;
      wr_data = 32'((i + 1) * 32'h11);
      step();
      check("fill_count", 32'(data_count), 32'(i + 1));
      check("fill_ack", 32'({wr_ack, wr_err}), 32'b10);
      check("fill_state", 32'(state), 32'd1);
      check("fill_af", 32'(almost_full), (i + 1 >= 6) ? 32'd1 : 32'd0);
      check("fill_ae", 32'(almost_empty), (i + 1 <= 2) ? 32'd1 : 32'd0);
      check("fill_full", 32'(full), (i == 7) ? 32'd1 : 32'd0);
    end

    // Overflow attempt
    wr_data = 32'h99;
    step();
    check("ovf_ack", 32'({wr_ack, wr_err}), 32'b01);
    check("ovf_state", 32'(state), 32'd3);
    check("ovf_count", 32'(data_count), 32'd8);

    // Drain in order; the rejected 0x99 must not appear
    wr_en = 1'b0;
    for (int i = 0; i < 8; i++) begin
      rd_en = 1'b1;
      step();
      check("drain_data", rd_data, 32'((i + 1) * 32'h11));
      check("drain_ack", 32'({rd_ack, rd_err}), 32'b10);
      check("drain_state", 32'(state), 32'd2);
      check("drain_count", 32'(data_count), 32'(7 - i));
    end
    check("drain_empty", 32'(empty), 32'd1);

    // Underflow attempt
    step();
    check("udf_ack", 32'({rd_ack, rd_err}), 32'b01);
    check("udf_state", 32'(state), 32'd4);
    check("udf_hold", rd_data, 32'h88);

    rd_en = 1'b0;
    step();
    check("noop_state", 32'(state), 32'd7);
    check("noop_acks", 32'({wr_ack, wr_err, rd_ack, rd_err}), 32'd0);

    // Simultaneous on empty: write taken, read refused
    wr_en   = 1'b1;
    rd_en   = 1'b1;
    wr_data = 32'hAB;
    step();
    check("we_acks", 32'({wr_ack, wr_err, rd_ack, rd_err}), 32'b1001);
    check("we_state", 32'(state), 32'd4);
    check("we_count", 32'(data_count), 32'd1);
    check("we_hold", rd_data, 32'h88);
    wr_en = 1'b0;
    step();
    check("we_read", rd_data, 32'hAB);
    check("we_rstate", 32'(state), 32'd2);
    check("we_rcount", 32'(data_count), 32'd0);

    // Refill with pointers offset, then sustained read+write across wrap
    rd_en = 1'b0;
    wr_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      wr_data = 32'h100 + 32'(i);
      sb.push_back(wr_data);
      step();
    end
    check("refill_full", 32'(full), 32'd1);
    rd_en = 1'b1;
    for (int k = 0; k < 20; k++) begin
      wr_data = 32'h200 + 32'(k);
      exp_word = sb.pop_front();
      sb.push_back(wr_data);
      step();
      check("wr_rd_data", rd_data, exp_word);
      check("wr_rd_count", 32'(data_count), 32'd8);
      check("wr_rd_state", 32'(state), 32'd5);
      check("wr_rd_acks", 32'({wr_ack, wr_err, rd_ack, rd_err}), 32'b1010);
    end

    // Drain to 5 entries
    wr_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      exp_word = sb.pop_front();
      step();
      check("part_data", rd_data, exp_word);
    end
    check("part_count", 32'(data_count), 32'd5);

    // Asynchronous reset between edges while a write is being requested
    rd_en   = 1'b0;
    wr_en   = 1'b1;
    wr_data = 32'h77;
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_count", 32'(data_count), 32'd0);
    check("arst_empty", 32'(empty), 32'd1);
    check("arst_ae", 32'(almost_empty), 32'd1);
    check("arst_acks", 32'({wr_ack, wr_err, rd_ack, rd_err}), 32'd0);
    check("arst_state", 32'(state), 32'd0);
    check("arst_rd_data", rd_data, 32'd0);

    wr_en = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    wr_en   = 1'b1;
    wr_data = 32'h5A;
    step();
    check("post_count", 32'(data_count), 32'd1);
    wr_en = 1'b0;
    rd_en = 1'b1;
    step();
    check("post_read", rd_data, 32'h5A);
    rd_en = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
